// File: rtl/instruction_rom_loader.sv
// Loadable instruction ROM: takes a program image over a valid/ready channel, then serves
// zero-latency fetch reads. Optional checksum output is enabled by defining ROM_CHECKSUM_EN.
module instruction_rom_loader #(
  parameter int unsigned ADDRESS_WIDTH = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  input  logic                     reload,
  output logic                     loaded,
  output logic [ADDRESS_WIDTH:0]   word_count,
  output logic                     overflow,
  input  logic                     chip_enable,
  input  logic [31:0]              address,
`ifdef ROM_CHECKSUM_EN
  output logic [31:0]              checksum,
`endif
  output logic [31:0]              data
);

  localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;

  localparam logic StLoad = 1'b0;
  localparam logic StDone = 1'b1;

  localparam logic [ADDRESS_WIDTH:0] CountOne  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDRESS_WIDTH:0] CountFull = {1'b1, {ADDRESS_WIDTH{1'b0}}};

  logic                   state_q, state_d;
  logic [ADDRESS_WIDTH:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   write_en;
  logic                   last_index;
  logic [31:0]            mem [DEPTH];

`ifdef ROM_CHECKSUM_EN
  logic [31:0]            checksum_q, checksum_d;
`endif

  assign last_index = (count_q[ADDRESS_WIDTH-1:0] == {ADDRESS_WIDTH{1'b1}});

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    write_en   = 1'b0;
`ifdef ROM_CHECKSUM_EN
    checksum_d = checksum_q;
`endif
    case (state_q)
      StLoad: begin
        // reload is deliberately not looked at here; loading always runs to completion
        if (load_valid) begin
          write_en = 1'b1;
          if (count_q != CountFull) count_d = count_q + CountOne;
          if (load_last || last_index) state_d = StDone;
          if (last_index && !load_last) overflow_d = 1'b1;
`ifdef ROM_CHECKSUM_EN
          checksum_d = checksum_q ^ load_data;
`endif
        end
      end
      default: begin
        if (reload) begin
          state_d    = StLoad;
          count_d    = '0;
          overflow_d = 1'b0;
`ifdef ROM_CHECKSUM_EN
          checksum_d = '0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StLoad;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef ROM_CHECKSUM_EN
      checksum_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef ROM_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  // No reset on the array: stale contents are hidden by the word_count bound
  always_ff @(posedge clock) begin
    if (write_en) mem[count_q[ADDRESS_WIDTH-1:0]] <= load_data;
  end

  logic [ADDRESS_WIDTH-1:0] rd_index;
  logic                     addr_in_range;
  logic                     unused_addr_bits;

  assign rd_index         = address[ADDRESS_WIDTH+1:2];
  assign addr_in_range    = ((address >> (ADDRESS_WIDTH + 2)) == 32'd0);
  assign unused_addr_bits = ^address[1:0];

  always_comb begin
    data = 32'h0;
    if (chip_enable && (state_q == StDone) && addr_in_range && ({1'b0, rd_index} < count_q)) begin
      data = mem[rd_index];
    end
  end

  assign load_ready = (state_q == StLoad);
  assign loaded     = (state_q == StDone);
  assign word_count = count_q;
  assign overflow   = overflow_q;
`ifdef ROM_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_instruction_rom_loader.sv
// Directed bench for instruction_rom_loader: a default-size instance and an
// ADDRESS_WIDTH=2 instance for the overflow case. Checksum checks need ROM_CHECKSUM_EN.
module tb_instruction_rom_loader;

  logic        clock;
  logic        reset;

  logic        load_valid, load_last, reload, chip_enable;
  logic [31:0] load_data, address;
  logic        load_ready, loaded, overflow;
  logic [10:0] word_count;
  logic [31:0] data;

  logic        s_load_valid, s_load_last, s_reload, s_chip_enable;
  logic [31:0] s_load_data, s_address;
  logic        s_load_ready, s_loaded, s_overflow;
  logic [2:0]  s_word_count;
  logic [31:0] s_data;

`ifdef ROM_CHECKSUM_EN
  logic [31:0] checksum, s_checksum;
`endif

  int compared;
  int mismatched;

  instruction_rom_loader #(.ADDRESS_WIDTH(10)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .reload      (reload),
    .loaded      (loaded),
    .word_count  (word_count),
    .overflow    (overflow),
    .chip_enable (chip_enable),
    .address     (address),
`ifdef ROM_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .data        (data)
  );

  instruction_rom_loader #(.ADDRESS_WIDTH(2)) u_small (
    .clock       (clock),
    .reset       (reset),
    .load_valid  (s_load_valid),
    .load_ready  (s_load_ready),
    .load_data   (s_load_data),
    .load_last   (s_load_last),
    .reload      (s_reload),
    .loaded      (s_loaded),
    .word_count  (s_word_count),
    .overflow    (s_overflow),
    .chip_enable (s_chip_enable),
    .address     (s_address),
`ifdef ROM_CHECKSUM_EN
    .checksum    (s_checksum),
`endif
    .data        (s_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    address = addr;
    #1;
    check(tag, data, exp);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b0;
    load_valid = 0; load_last = 0; reload = 0; chip_enable = 1; load_data = '0; address = '0;
    s_load_valid = 0; s_load_last = 0; s_reload = 0; s_chip_enable = 1; s_load_data = '0;
    s_address = '0;

    // Reset values
    #2;
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_loaded", {31'd0, loaded}, 32'd0);
    check("rst_word_count", {21'd0, word_count}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_data", data, 32'h0);
    #10 reset = 1'b1;

    // Three-word image; reload on the final handshake must be ignored
    load_valid = 1; load_data = 32'h3401_0001; load_last = 0;
    step();
    check("wc_after_1", {21'd0, word_count}, 32'd1);
    check("fetch_during_load", data, 32'h0);
    load_data = 32'h3402_0002;
    step();
    load_data = 32'h0022_1825; load_last = 1; reload = 1;
    step();
    load_valid = 0; load_last = 0; reload = 0;
    check("loaded_after_last", {31'd0, loaded}, 32'd1);
    check("wc_after_last", {21'd0, word_count}, 32'd3);
    check("ready_in_done", {31'd0, load_ready}, 32'd0);
    check("no_overflow", {31'd0, overflow}, 32'd0);
    read_chk("read_0", 32'h0, 32'h3401_0001);
    read_chk("read_4", 32'h4, 32'h3402_0002);
    read_chk("read_8", 32'h8, 32'h0022_1825);
    read_chk("read_c_beyond", 32'hC, 32'h0);
    read_chk("read_misaligned_5", 32'h5, 32'h3402_0002);
    read_chk("read_out_of_range", 32'h0000_1000, 32'h0);
    chip_enable = 0;
    read_chk("read_ce_low", 32'h0, 32'h0);
    chip_enable = 1;

    // load_valid ignored while DONE
    load_valid = 1; load_data = 32'hFFFF_FFFF;
    step();
    load_valid = 0;
    check("done_ignores_load", {21'd0, word_count}, 32'd3);
    read_chk("done_no_write", 32'hC, 32'h0);

    // reload pulse
    reload = 1;
    step();
    reload = 0;
    check("reload_loaded", {31'd0, loaded}, 32'd0);
    check("reload_wc", {21'd0, word_count}, 32'd0);
    read_chk("reload_read_0", 32'h0, 32'h0);

    // Reset after two of three words
    load_valid = 1; load_data = 32'h1111_1111;
    step();
    load_data = 32'h2222_2222;
    step();
    load_valid = 0;
    reset = 1'b0;
    #1;
    check("midload_rst_loaded", {31'd0, loaded}, 32'd0);
    check("midload_rst_wc", {21'd0, word_count}, 32'd0);
    #1 reset = 1'b1;
    load_valid = 1; load_data = 32'hDEAD_BEEF; load_last = 1;
    step();
    load_valid = 0; load_last = 0;
    check("single_loaded", {31'd0, loaded}, 32'd1);
    read_chk("single_read_0", 32'h0, 32'hDEAD_BEEF);
    read_chk("single_read_4_stale", 32'h4, 32'h0);

`ifdef ROM_CHECKSUM_EN
    reload = 1;
    step();
    reload = 0;
    check("cs_after_reload0", checksum, 32'h0);
    load_valid = 1; load_data = 32'h0000_FFFF;
    step();
    load_data = 32'hFFFF_0000; load_last = 1;
    step();
    load_valid = 0; load_last = 0;
    check("cs_full", checksum, 32'hFFFF_FFFF);
    reload = 1;
    step();
    reload = 0;
    check("cs_cleared", checksum, 32'h0);
    check("cs_reload_loaded", {31'd0, loaded}, 32'd0);
`endif

    // ADDRESS_WIDTH=2: four words without load_last overflow the image
    s_load_valid = 1;
    for (int i = 0; i < 4; i++) begin
      s_load_data = 32'h11 * (i + 1);
      if (i == 3) begin
        #1;
        check("small_ovf_before_last", {31'd0, s_overflow}, 32'd0);
        check("small_ready_before_last", {31'd0, s_load_ready}, 32'd1);
      end
      step();
    end
    check("small_loaded", {31'd0, s_loaded}, 32'd1);
    check("small_overflow", {31'd0, s_overflow}, 32'd1);
    check("small_wc", {29'd0, s_word_count}, 32'd4);
    check("small_ready_low", {31'd0, s_load_ready}, 32'd0);
    s_load_data = 32'h55;
    step();
    s_load_valid = 0;
    check("small_5th_rejected", {29'd0, s_word_count}, 32'd4);
    s_address = 32'hC;
    #1;
    check("small_read_c", s_data, 32'h44);
    s_address = 32'h0;
    #1;
    check("small_read_0", s_data, 32'h11);
    s_address = 32'h10;
    #1;
    check("small_read_oob", s_data, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instruction_rom_loader.md
# instruction_rom_loader

Loadable instruction memory sitting directly upstream of the CPU core's fetch stage; it drives the core's instruction ROM port (chip enable, address, data). After reset it accepts a program image word by word over a valid/ready load channel, then serves zero-latency reads to the fetch stage. Until loading completes, every read returns 32'h0, which the core treats as a NOP (sll $0,$0,0).

## Interface
Parameters:
- ADDRESS_WIDTH, 10, word-address width; DEPTH = 2**ADDRESS_WIDTH words.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- load_valid  in  1  load word offered.
- load_ready  out  1  loader accepts a word this cycle.
- load_data  in  32  instruction word to store.
- load_last  in  1  qualifies the final word of the image.
- reload  in  1  single-cycle request to restart loading (honoured only in DONE).
- loaded  out  1  image complete; reads active.
- word_count  out  ADDRESS_WIDTH+1  number of words stored.
- overflow  out  1  image hit DEPTH without load_last.
- chip_enable  in  1  fetch-stage read enable.
- address  in  32  fetch byte address (program counter).
- data  out  32  instruction word to the fetch stage.
- checksum  out  32  XOR of all loaded words (present only with ROM_CHECKSUM_EN).

## Operation
- States: LOAD and DONE. Reset enters LOAD.
- LOAD:
  - load_ready=1, loaded=0.
  - Handshake (load_valid && load_ready) at a clock edge: mem[word_count] <= load_data; word_count increments.
  - Transition to DONE when the handshake carries load_last=1, or when the write targets index DEPTH-1.
  - Write at index DEPTH-1 with load_last=0: also set overflow=1.
  - reload is ignored in LOAD.
- DONE:
  - load_ready=0, loaded=1; load_valid is ignored.
  - reload=1: go to LOAD; word_count<=0; overflow<=0; checksum<=0.
  - Memory contents are not cleared; the word_count bound hides stale words.
- Read path (combinational):
  - data = mem[address[ADDRESS_WIDTH+1:2]] when all of the following hold: chip_enable=1, loaded=1, address[31:ADDRESS_WIDTH+2]==0, index < word_count.
  - Otherwise data = 32'h0.
  - address[1:0] is ignored.
- Memory array has no reset; contents survive reset, but are invisible until reloaded because word_count resets to 0.

## Timing
- Reset values: load_ready=1, loaded=0, word_count=0, overflow=0, checksum=0, data=0.
- Load throughput: one word per cycle. A write is visible for reads from the cycle after its handshake edge.
- loaded rises on the edge that accepts the final word. The first valid fetch is the following cycle.
- Read latency: zero cycles; data is valid in the same cycle as address. This matches the fetch stage sampling ROM data together with the program counter.
- Load handshake and reload asserted in the same cycle while in LOAD: the load is accepted and reload is ignored.
- Reset asserted mid-load: state returns to LOAD immediately, word_count=0. Partial words already written are discarded by the word_count bound.
- word_count saturates at DEPTH; no wrap-around.

## Configuration
- ROM_CHECKSUM_EN defined:
  - checksum port exists.
  - Each accepted load word updates checksum <= checksum ^ load_data.
  - checksum is cleared by reset and by reload.
- ROM_CHECKSUM_EN undefined: the checksum port and its register are absent; all other behaviour is identical.

## Test plan
- Load words 0x34010001, 0x34020002, 0x00221825, with load_last on the third word -> loaded=1, word_count=3. Reads at address 0x0/0x4/0x8 return those words; read at 0xC returns 0.
- Fetch during LOAD with chip_enable=1, address=0 -> data=0. Drop chip_enable after load -> data=0.
- ADDRESS_WIDTH=2: stream 4 words without load_last -> DONE, overflow=1, word_count=4. A 5th load_valid is not accepted (load_ready=0).
- Out-of-range read: address=0x00001000 with ADDRESS_WIDTH=10 -> data=0. Misaligned address 0x5 returns the word at 0x4.
- Reset asserted after 2 of 3 words -> loaded=0, word_count=0. Reload of 1 word 0xDEADBEEF with load_last -> read at 0x0 returns 0xDEADBEEF, read at 0x4 returns 0.
- ROM_CHECKSUM_EN build: load 0x0000FFFF, 0xFFFF0000 -> checksum=0xFFFFFFFF. Pulse reload -> checksum=0, loaded=0.
